// File: rtl/disp_mux_scanner.sv
// Two-digit seven-segment scan controller: ON0 -> BLANK0 -> ON1 -> BLANK1, frame-synchronous digit updates.
// Define DISP_MUX_DIM_EN to add a 4-bit duty input that trims the lit portion of each ON state.
module disp_mux_scanner #(
  parameter int ON_CYCLES    = 200000,
  parameter int BLANK_CYCLES = 2000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  input  logic       load,
`ifdef DISP_MUX_DIM_EN
  input  logic [3:0] duty,
`endif
  output logic       select,
  output logic [1:0] anode_n,
  output logic [3:0] hex_out,
  output logic       frame_done
);

  localparam int MAX_CYCLES = (ON_CYCLES > BLANK_CYCLES) ? ON_CYCLES : BLANK_CYCLES;
  localparam int CNT_W      = $clog2(MAX_CYCLES);
  localparam logic [CNT_W-1:0] ON_LOAD    = CNT_W'(ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] BLANK_LOAD = CNT_W'(BLANK_CYCLES - 1);

  typedef enum logic [1:0] {ON0, BLANK0, ON1, BLANK1} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       stage0_q, stage0_d, stage1_q, stage1_d;
  logic [3:0]       shadow0_q, shadow0_d, shadow1_q, shadow1_d;
  logic             select_q, select_d;
  logic [1:0]       anode_n_q, anode_n_d;
  logic [3:0]       hex_out_q, hex_out_d;
  logic             frame_done_q, frame_done_d;
  logic             lit_d;

`ifdef DISP_MUX_DIM_EN
  localparam int PW = CNT_W + 5;
  logic [3:0]    duty_q, duty_d;
  logic [PW-1:0] elapsed_x16, lit_limit;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q - CNT_W'(1);
    stage0_d     = load ? digit0 : stage0_q;
    stage1_d     = load ? digit1 : stage1_q;
    shadow0_d    = shadow0_q;
    shadow1_d    = shadow1_q;
    frame_done_d = 1'b0;
`ifdef DISP_MUX_DIM_EN
    duty_d       = duty_q;
`endif
    if (cnt_q == '0) begin
      case (state_q)
        ON0: begin
          state_d = BLANK0;
          cnt_d   = BLANK_LOAD;
        end
        BLANK0: begin
          state_d = ON1;
          cnt_d   = ON_LOAD;
        end
        ON1: begin
          state_d = BLANK1;
          cnt_d   = BLANK_LOAD;
        end
        default: begin
          // Frame boundary: display takes the staging value held before this edge.
          state_d      = ON0;
          cnt_d        = ON_LOAD;
          shadow0_d    = stage0_q;
          shadow1_d    = stage1_q;
          frame_done_d = 1'b1;
`ifdef DISP_MUX_DIM_EN
          duty_d       = duty;
`endif
        end
      endcase
    end
  end

  always_comb begin
    select_d  = (state_d == ON1) || (state_d == BLANK1);
    hex_out_d = select_d ? shadow1_d : shadow0_d;
`ifdef DISP_MUX_DIM_EN
    // Elapsed index k is lit while k*16 < (duty+1)*ON_CYCLES.
    elapsed_x16 = PW'(ON_LOAD - cnt_d) << 4;
    lit_limit   = PW'(duty_d) * PW'(ON_CYCLES) + PW'(ON_CYCLES);
    lit_d       = elapsed_x16 < lit_limit;
`else
    lit_d = 1'b1;
`endif
    case (state_d)
      ON0:     anode_n_d = lit_d ? 2'b10 : 2'b11;
      ON1:     anode_n_d = lit_d ? 2'b01 : 2'b11;
      default: anode_n_d = 2'b11;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= BLANK1;
      cnt_q        <= BLANK_LOAD;
      stage0_q     <= 4'h0;
      stage1_q     <= 4'h0;
      shadow0_q    <= 4'h0;
      shadow1_q    <= 4'h0;
      select_q     <= 1'b1;
      anode_n_q    <= 2'b11;
      hex_out_q    <= 4'h0;
      frame_done_q <= 1'b0;
`ifdef DISP_MUX_DIM_EN
      duty_q       <= 4'hF;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      stage0_q     <= stage0_d;
      stage1_q     <= stage1_d;
      shadow0_q    <= shadow0_d;
      shadow1_q    <= shadow1_d;
      select_q     <= select_d;
      anode_n_q    <= anode_n_d;
      hex_out_q    <= hex_out_d;
      frame_done_q <= frame_done_d;
`ifdef DISP_MUX_DIM_EN
      duty_q       <= duty_d;
`endif
    end
  end

  assign select     = select_q;
  assign anode_n    = anode_n_q;
  assign hex_out    = hex_out_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_disp_mux_scanner.sv
// Self-checking bench for disp_mux_scanner: directed vector table, dimming sequence, randomized run vs. frame-phase model.
module tb_disp_mux_scanner;

  localparam int ON = 8;
  localparam int BL = 2;
  localparam int F  = 2 * ON + 2 * BL;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] digit0 = 4'h0;
  logic [3:0] digit1 = 4'h0;
  logic       load = 1'b0;
  logic [3:0] duty = 4'hF;
  logic       select;
  logic [1:0] anode_n;
  logic [3:0] hex_out;
  logic       frame_done;

  int errors = 0;
  int checks = 0;

  // Reference model: position within the 20-cycle frame plus staging/shadow copies.
  int         ph = 0;
  logic [3:0] stg0 = 4'h0, stg1 = 4'h0, sh0 = 4'h0, sh1 = 4'h0, dty = 4'hF;

  typedef struct {
    logic       rst;
    logic       ld;
    logic [3:0] d0;
    logic [3:0] d1;
    int         reps;
    logic [1:0] an;
    logic       sel;
    logic [3:0] hx;
    logic       fd;
  } vec_t;

  vec_t vecs[$];

  disp_mux_scanner #(.ON_CYCLES(ON), .BLANK_CYCLES(BL)) dut (
    .clk(clk),
    .reset(reset),
    .digit0(digit0),
    .digit1(digit1),
    .load(load),
`ifdef DISP_MUX_DIM_EN
    .duty(duty),
`endif
    .select(select),
    .anode_n(anode_n),
    .hex_out(hex_out),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(input logic r, input logic l, input logic [3:0] a, input logic [3:0] b,
                              input int n, input logic [1:0] an, input logic sel, input logic [3:0] hx,
                              input logic fd);
    vec_t v;
    v.rst = r; v.ld = l; v.d0 = a; v.d1 = b; v.reps = n;
    v.an = an; v.sel = sel; v.hx = hx; v.fd = fd;
    return v;
  endfunction

  // Drives one cycle of inputs, waits past the edge, and advances the model.
  task automatic applyStimulus(input logic r, input logic l, input logic [3:0] a, input logic [3:0] b);
    reset = r; load = l; digit0 = a; digit1 = b;
    @(posedge clk);
    #1;
    if (r) begin
      ph = F - BL;
      stg0 = 4'h0; stg1 = 4'h0; sh0 = 4'h0; sh1 = 4'h0; dty = 4'hF;
    end else begin
      ph = (ph + 1) % F;
      if (ph == 0) begin
        sh0 = stg0; sh1 = stg1; dty = duty;
      end
      if (l) begin
        stg0 = a; stg1 = b;
      end
    end
  endtask

  task automatic modelExpect(output logic [1:0] an, output logic sel, output logic [3:0] hx, output logic fd);
    int k;
    k   = 0;
    sel = (ph >= ON + BL);
    hx  = sel ? sh1 : sh0;
    fd  = (ph == 0);
    if (ph < ON) begin
      k = ph; an = 2'b10;
    end else if (ph >= ON + BL && ph < 2 * ON + BL) begin
      k = ph - ON - BL; an = 2'b01;
    end else begin
      an = 2'b11;
    end
    if (an != 2'b11 && k * 16 >= (int'(dty) + 1) * ON) an = 2'b11;
  endtask

  task automatic checkOutput(input string name, input logic [1:0] an, input logic sel, input logic [3:0] hx,
                             input logic fd);
    checks += 5;
    if (anode_n !== an) begin
      errors++;
      $display("[TB] FAIL %s anode_n: got %b want %b (t=%0t)", name, anode_n, an, $time);
    end
    if (select !== sel) begin
      errors++;
      $display("[TB] FAIL %s select: got %b want %b (t=%0t)", name, select, sel, $time);
    end
    if (hex_out !== hx) begin
      errors++;
      $display("[TB] FAIL %s hex_out: got %h want %h (t=%0t)", name, hex_out, hx, $time);
    end
    if (frame_done !== fd) begin
      errors++;
      $display("[TB] FAIL %s frame_done: got %b want %b (t=%0t)", name, frame_done, fd, $time);
    end
    if (anode_n === 2'b00) begin
      errors++;
      $display("[TB] FAIL %s anode_both_on: got %b want not 00 (t=%0t)", name, anode_n, $time);
    end
  endtask

  initial begin
    logic [1:0] e_an;
    logic       e_sel, e_fd;
    logic [3:0] e_hx;
    logic       prev_sel, prev_rst;
    logic [1:0] prev_an;
    logic       r, l;

    // Directed frames: reset, mid-ON1 load, load on the frame edge, mid-frame reset.
    vecs.push_back(mk(1, 0, 4'h0, 4'h0, 1, 2'b11, 1, 4'h0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 4'h0, 1, 2'b11, 1, 4'h0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 4'h0, 1, 2'b10, 0, 4'h0, 1));
    vecs.push_back(mk(0, 0, 4'h0, 4'h0, 7, 2'b10, 0, 4'h0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 4'h0, 2, 2'b11, 0, 4'h0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 4'h0, 3, 2'b01, 1, 4'h0, 0));
    vecs.push_back(mk(0, 1, 4'hA, 4'h5, 1, 2'b01, 1, 4'h0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 4'h0, 4, 2'b01, 1, 4'h0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 4'h0, 2, 2'b11, 1, 4'h0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 4'h0, 1, 2'b10, 0, 4'hA, 1));
    vecs.push_back(mk(0, 1, 4'h7, 4'h9, 1, 2'b10, 0, 4'hA, 0));
    vecs.push_back(mk(0, 0, 4'h0, 4'h0, 6, 2'b10, 0, 4'hA, 0));
    vecs.push_back(mk(0, 0, 4'h0, 4'h0, 2, 2'b11, 0, 4'hA, 0));
    vecs.push_back(mk(0, 0, 4'h0, 4'h0, 8, 2'b01, 1, 4'h5, 0));
    vecs.push_back(mk(0, 0, 4'h0, 4'h0, 2, 2'b11, 1, 4'h5, 0));
    vecs.push_back(mk(0, 1, 4'h3, 4'h6, 1, 2'b10, 0, 4'h7, 1));
    vecs.push_back(mk(0, 0, 4'h0, 4'h0, 7, 2'b10, 0, 4'h7, 0));
    vecs.push_back(mk(0, 0, 4'h0, 4'h0, 2, 2'b11, 0, 4'h7, 0));
    vecs.push_back(mk(0, 0, 4'h0, 4'h0, 8, 2'b01, 1, 4'h9, 0));
    vecs.push_back(mk(0, 0, 4'h0, 4'h0, 2, 2'b11, 1, 4'h9, 0));
    vecs.push_back(mk(0, 0, 4'h0, 4'h0, 1, 2'b10, 0, 4'h3, 1));
    vecs.push_back(mk(0, 0, 4'h0, 4'h0, 7, 2'b10, 0, 4'h3, 0));
    vecs.push_back(mk(0, 0, 4'h0, 4'h0, 2, 2'b11, 0, 4'h3, 0));
    vecs.push_back(mk(0, 1, 4'hE, 4'hD, 3, 2'b01, 1, 4'h6, 0));
    vecs.push_back(mk(1, 0, 4'h0, 4'h0, 1, 2'b11, 1, 4'h0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 4'h0, 1, 2'b11, 1, 4'h0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 4'h0, 1, 2'b10, 0, 4'h0, 1));
    vecs.push_back(mk(0, 0, 4'h0, 4'h0, 7, 2'b10, 0, 4'h0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 4'h0, 2, 2'b11, 0, 4'h0, 0));
    vecs.push_back(mk(0, 0, 4'h0, 4'h0, 8, 2'b01, 1, 4'h0, 0));

    $display("[TB] directed vectors");
    duty = 4'hF;
    foreach (vecs[i]) begin
      for (int n = 0; n < vecs[i].reps; n++) begin
        applyStimulus(vecs[i].rst, vecs[i].ld, vecs[i].d0, vecs[i].d1);
        checkOutput($sformatf("vec%0d", i), vecs[i].an, vecs[i].sel, vecs[i].hx, vecs[i].fd);
      end
    end

`ifdef DISP_MUX_DIM_EN
    // duty=7 lights half of each ON state; duty=15 restores full on-time next frame.
    $display("[TB] dimming sequence");
    duty = 4'h7;
    applyStimulus(1, 0, 4'h0, 4'h0);
    applyStimulus(0, 0, 4'h0, 4'h0);
    for (int k = 0; k < ON; k++) begin
      applyStimulus(0, 0, 4'h0, 4'h0);
      checkOutput("dim7_on0", (k < 4) ? 2'b10 : 2'b11, 1'b0, 4'h0, (k == 0));
    end
    for (int k = 0; k < BL; k++) applyStimulus(0, 0, 4'h0, 4'h0);
    duty = 4'hF;
    for (int k = 0; k < ON; k++) begin
      applyStimulus(0, 0, 4'h0, 4'h0);
      checkOutput("dim7_on1", (k < 4) ? 2'b01 : 2'b11, 1'b1, 4'h0, 1'b0);
    end
    for (int k = 0; k < BL; k++) applyStimulus(0, 0, 4'h0, 4'h0);
    for (int k = 0; k < ON; k++) begin
      applyStimulus(0, 0, 4'h0, 4'h0);
      checkOutput("dim15_on0", 2'b10, 1'b0, 4'h0, (k == 0));
    end
`endif

    $display("[TB] randomized run");
    applyStimulus(1, 0, 4'h0, 4'h0);
    modelExpect(e_an, e_sel, e_hx, e_fd);
    checkOutput("rand_reset", e_an, e_sel, e_hx, e_fd);
    prev_sel = select;
    prev_an  = anode_n;
    prev_rst = 1'b1;
    for (int c = 0; c < 800; c++) begin
      r = ($urandom_range(0, 149) == 0);
      l = ($urandom_range(0, 3) == 0);
`ifdef DISP_MUX_DIM_EN
      duty = 4'($urandom_range(0, 15));
`endif
      applyStimulus(r, l, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      modelExpect(e_an, e_sel, e_hx, e_fd);
      checkOutput("rand", e_an, e_sel, e_hx, e_fd);
      if (!r && !prev_rst && select !== prev_sel) begin
        checks++;
        if (prev_an !== 2'b11) begin
          errors++;
          $display("[TB] FAIL select_while_lit: prior anode_n %b want 11 (t=%0t)", prev_an, $time);
        end
      end
      prev_sel = select;
      prev_an  = anode_n;
      prev_rst = r;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
